// File: rtl/pong_pkg.sv
// Shared pong game-flow definitions.
// State encodings and winner codes used by the controller and overlays.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEW     = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/pong_timer.sv
// Loadable pause down-counter; holds at zero once expired.
// Ports: clk, reset (sync, high), load (start pause), done (count==0).
module pong_timer #(
  parameter int TIMER_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int TW =
    (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= TW'(TIMER_CYCLES - 1);
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: serve/pause/score/rally/winner.
// Ports: clk, reset, btn1/btn2, hit, miss, miss_side -> gra_still,
// game_state, balls_left, score1, score2, rally, winner.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_BALLS    = 3,
  parameter int BALL_W       = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int RALLY_W      = 8,
  parameter int TIMER_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         btn1,
  input  logic [1:0]         btn2,
  input  logic               hit,
  input  logic               miss,
  input  logic               miss_side,
  output logic               gra_still,
  output logic [1:0]         game_state,
  output logic [BALL_W-1:0]  balls_left,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [RALLY_W-1:0] rally,
  output logic [1:0]         winner
);

  state_t state, state_nx;

  logic               any_btn;
  logic               done;
  logic               load;
  logic               game_end;
  logic [SCORE_W-1:0] new_s1, new_s2, opp;
  logic [BALL_W-1:0]  balls_nx;
  logic [SCORE_W-1:0] score1_nx, score2_nx;
  logic [RALLY_W-1:0] rally_nx;
  logic [1:0]         winner_nx;

  function automatic logic [1:0] win_of(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b
  );
    if (a > b)      return WIN_P1;
    else if (b > a) return WIN_P2;
    else            return WIN_DRAW;
  endfunction

  assign any_btn = ((btn1 | btn2) != 2'b00);

  // Point goes to the opponent of the side that missed.
  always_comb begin
    new_s1 = score1;
    new_s2 = score2;
    if (miss_side) begin
      if (score1 != '1) new_s1 = score1 + 1'b1;
    end else begin
      if (score2 != '1) new_s2 = score2 + 1'b1;
    end
    opp = miss_side ? new_s1 : new_s2;
    game_end = (balls_left == '0) ||
      ((WIN_SCORE != 0) && (int'(opp) >= WIN_SCORE));
  end

  pong_timer #(
    .TIMER_CYCLES(TIMER_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_NEW;
      gra_still  <= 1'b1;
      balls_left <= BALL_W'(NUM_BALLS);
      score1     <= '0;
      score2     <= '0;
      rally      <= '0;
      winner     <= WIN_NONE;
    end else begin
      state      <= state_nx;
      gra_still  <= (state_nx != ST_PLAY);
      balls_left <= balls_nx;
      score1     <= score1_nx;
      score2     <= score2_nx;
      rally      <= rally_nx;
      winner     <= winner_nx;
    end
  end

  assign game_state = state;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_NEW:
        if (any_btn) state_nx = ST_PLAY;
      ST_PLAY:
        if (miss)
          state_nx = game_end ? ST_OVER : ST_NEWBALL;
      ST_NEWBALL:
        if (done && any_btn) state_nx = ST_PLAY;
      ST_OVER:
        if (done) state_nx = ST_NEW;
      default:
        state_nx = ST_NEW;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    balls_nx  = balls_left;
    score1_nx = score1;
    score2_nx = score2;
    rally_nx  = rally;
    winner_nx = winner;
    unique case (state)
      ST_NEW:
        if (any_btn) begin
          balls_nx  = BALL_W'(NUM_BALLS - 1);
          score1_nx = '0;
          score2_nx = '0;
          rally_nx  = '0;
          winner_nx = WIN_NONE;
        end
      ST_PLAY:
        if (miss) begin
          load      = 1'b1;
          score1_nx = new_s1;
          score2_nx = new_s2;
          rally_nx  = '0;
          if (game_end)
            winner_nx = win_of(new_s1, new_s2);
          else
            balls_nx = balls_left - 1'b1;
        end else if (hit) begin
          if (rally != '1) rally_nx = rally + 1'b1;
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl.
// Three DUTs: default (T=4), WIN_SCORE=2 (T=4), zero-wait (T=1).
module tb_pong_game_ctrl;
  import pong_pkg::*;

  typedef struct packed {
    logic [1:0] st;
    logic       still;
    logic [1:0] balls;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [7:0] rally;
    logic [1:0] win;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       hit;
    logic       miss;
    logic       side;
    logic [1:0] b1;
    logic [1:0] b2;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       miss_side = 1'b0;
  logic [1:0] btn1 = 2'b00;
  logic [1:0] btn2 = 2'b00;

  logic       a_still, b_still, c_still;
  logic [1:0] a_st, b_st, c_st;
  logic [1:0] a_balls, b_balls, c_balls;
  logic [3:0] a_s1, b_s1, c_s1;
  logic [3:0] a_s2, b_s2, c_s2;
  logic [7:0] a_rally, b_rally, c_rally;
  logic [1:0] a_win, b_win, c_win;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .NUM_BALLS(3), .BALL_W(2), .SCORE_W(4),
    .WIN_SCORE(7), .RALLY_W(8), .TIMER_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2),
    .hit(hit), .miss(miss), .miss_side(miss_side),
    .gra_still(a_still), .game_state(a_st),
    .balls_left(a_balls), .score1(a_s1), .score2(a_s2),
    .rally(a_rally), .winner(a_win)
  );

  pong_game_ctrl #(
    .NUM_BALLS(3), .BALL_W(2), .SCORE_W(4),
    .WIN_SCORE(2), .RALLY_W(8), .TIMER_CYCLES(4)
  ) dut_b (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2),
    .hit(hit), .miss(miss), .miss_side(miss_side),
    .gra_still(b_still), .game_state(b_st),
    .balls_left(b_balls), .score1(b_s1), .score2(b_s2),
    .rally(b_rally), .winner(b_win)
  );

  pong_game_ctrl #(
    .NUM_BALLS(3), .BALL_W(2), .SCORE_W(4),
    .WIN_SCORE(7), .RALLY_W(8), .TIMER_CYCLES(1)
  ) dut_c (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2),
    .hit(hit), .miss(miss), .miss_side(miss_side),
    .gra_still(c_still), .game_state(c_st),
    .balls_left(c_balls), .score1(c_s1), .score2(c_s2),
    .rally(c_rally), .winner(c_win)
  );

  obs_t  exp_q[$];
  stim_t stim_q[$];
  int    n_run  = 0;
  int    n_fail = 0;

  function automatic obs_t mk(int st, int still, int b,
                              int s1, int s2, int r, int w);
    obs_t o;
    o.st    = 2'(st);
    o.still = 1'(still);
    o.balls = 2'(b);
    o.s1    = 4'(s1);
    o.s2    = 4'(s2);
    o.rally = 8'(r);
    o.win   = 2'(w);
    return o;
  endfunction

  function automatic stim_t sv(int r, int h, int m, int s,
                               int b1, int b2);
    stim_t x;
    x.rst  = 1'(r);
    x.hit  = 1'(h);
    x.miss = 1'(m);
    x.side = 1'(s);
    x.b1   = 2'(b1);
    x.b2   = 2'(b2);
    return x;
  endfunction

  function automatic obs_t obs(int w);
    obs_t o;
    case (w)
      1: o = {b_st, b_still, b_balls, b_s1, b_s2, b_rally, b_win};
      2: o = {c_st, c_still, c_balls, c_s1, c_s2, c_rally, c_win};
      default:
         o = {a_st, a_still, a_balls, a_s1, a_s2, a_rally, a_win};
    endcase
    return o;
  endfunction

  task automatic add(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    {reset, hit, miss, miss_side, btn1, btn2} = s;
    @(posedge clk);
    #1;
    {reset, hit, miss, miss_side, btn1, btn2} = '0;
  endtask

  task automatic test_reset();
    stim_t s;
    obs_t  got, want;
    add(sv(1,0,0,0,0,0), mk(ST_NEW,1,3,0,0,0,WIN_NONE));
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      got  = obs(0);
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_start_rally_miss();
    stim_t s;
    obs_t  got, want;
    add(sv(0,0,0,0,1,0), mk(ST_PLAY,0,2,0,0,0,0));
    for (int k = 1; k <= 3; k++)
      add(sv(0,1,0,0,0,0), mk(ST_PLAY,0,2,0,0,k,0));
    add(sv(0,0,1,0,0,0), mk(ST_NEWBALL,1,1,0,1,0,0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      got  = obs(0);
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rally_miss[%0d] got=%h want=%h",
                 i, got, want);
      end
    end
  endtask

  task automatic test_countdown();
    stim_t s;
    obs_t  got, want;
    for (int k = 0; k < 3; k++)
      add(sv(0,0,0,0,0,1), mk(ST_NEWBALL,1,1,0,1,0,0));
    for (int k = 0; k < 2; k++)
      add(sv(0,0,0,0,0,0), mk(ST_NEWBALL,1,1,0,1,0,0));
    add(sv(0,0,0,0,0,1), mk(ST_PLAY,0,1,0,1,0,0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      got  = obs(0);
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL countdown[%0d] got=%h want=%h",
                 i, got, want);
      end
    end
  endtask

  task automatic test_game_over();
    stim_t s;
    obs_t  got, want;
    add(sv(0,0,1,1,0,0), mk(ST_NEWBALL,1,0,1,1,0,0));
    for (int k = 0; k < 4; k++)
      add(sv(0,0,0,0,0,0), mk(ST_NEWBALL,1,0,1,1,0,0));
    add(sv(0,0,0,0,2,0), mk(ST_PLAY,0,0,1,1,0,0));
    add(sv(0,1,0,0,0,0), mk(ST_PLAY,0,0,1,1,1,0));
    add(sv(0,1,1,0,0,0), mk(ST_OVER,1,0,1,2,0,WIN_P2));
    add(sv(0,1,0,0,0,0), mk(ST_OVER,1,0,1,2,0,WIN_P2));
    add(sv(0,0,1,1,0,0), mk(ST_OVER,1,0,1,2,0,WIN_P2));
    add(sv(0,1,1,0,0,0), mk(ST_OVER,1,0,1,2,0,WIN_P2));
    add(sv(0,0,0,0,0,0), mk(ST_NEW,1,0,1,2,0,WIN_P2));
    add(sv(0,1,0,0,0,0), mk(ST_NEW,1,0,1,2,0,WIN_P2));
    add(sv(0,0,1,0,0,0), mk(ST_NEW,1,0,1,2,0,WIN_P2));
    add(sv(0,0,0,0,1,0), mk(ST_PLAY,0,2,0,0,0,WIN_NONE));
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      got  = obs(0);
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL game_over[%0d] got=%h want=%h",
                 i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    obs_t  got, want;
    add(sv(0,0,1,1,0,0), mk(ST_NEWBALL,1,1,1,0,0,0));
    add(sv(0,0,0,0,0,0), mk(ST_NEWBALL,1,1,1,0,0,0));
    add(sv(1,0,0,0,0,0), mk(ST_NEW,1,3,0,0,0,WIN_NONE));
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      got  = obs(0);
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] got=%h want=%h",
                 i, got, want);
      end
    end
  endtask

  task automatic test_win_score();
    stim_t s;
    obs_t  got, want;
    add(sv(1,0,0,0,0,0), mk(ST_NEW,1,3,0,0,0,0));
    add(sv(0,0,0,0,1,0), mk(ST_PLAY,0,2,0,0,0,0));
    add(sv(0,1,0,0,0,0), mk(ST_PLAY,0,2,0,0,1,0));
    add(sv(0,1,1,1,0,0), mk(ST_NEWBALL,1,1,1,0,0,0));
    for (int k = 0; k < 4; k++)
      add(sv(0,0,0,0,0,0), mk(ST_NEWBALL,1,1,1,0,0,0));
    add(sv(0,0,0,0,0,3), mk(ST_PLAY,0,1,1,0,0,0));
    add(sv(0,0,1,1,0,0), mk(ST_OVER,1,1,2,0,0,WIN_P1));
    for (int k = 0; k < 3; k++)
      add(sv(0,0,0,0,0,0), mk(ST_OVER,1,1,2,0,0,WIN_P1));
    add(sv(0,0,0,0,0,0), mk(ST_NEW,1,1,2,0,0,WIN_P1));
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      got  = obs(1);
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL win_score[%0d] got=%h want=%h",
                 i, got, want);
      end
    end
  endtask

  task automatic test_zero_wait();
    stim_t s;
    obs_t  got, want;
    add(sv(1,0,0,0,0,0), mk(ST_NEW,1,3,0,0,0,0));
    add(sv(0,0,0,0,1,0), mk(ST_PLAY,0,2,0,0,0,0));
    add(sv(0,0,1,0,0,0), mk(ST_NEWBALL,1,1,0,1,0,0));
    add(sv(0,0,0,0,1,0), mk(ST_PLAY,0,1,0,1,0,0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      got  = obs(2);
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL zero_wait[%0d] got=%h want=%h",
                 i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_rally_miss();
    test_countdown();
    test_game_over();
    test_reset_mid();
    test_win_score();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Parametrised game-flow controller for the two-player pong design. It replaces the fixed new/play/over sequencing and adds a new-ball state, a countdown timer, a configurable ball budget, per-player scoring with a win threshold, rally counting and a winner flag. It sits between the VGA/graph units and the button inputs: it consumes hit/miss events from the graph unit and drives gra_still plus score and status signals to the graph and text overlays.

Parameters:
NUM_BALLS, 3, balls per game (>=1)
BALL_W, 2, width of balls_left; must hold NUM_BALLS
SCORE_W, 4, width of each player score
WIN_SCORE, 7, score that ends the game immediately; 0 disables score-based end
RALLY_W, 8, width of the rally (consecutive hit) counter
TIMER_CYCLES, 50000000, pause length in NEWBALL/OVER (2 s at 25 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn1  in  2  player 1 buttons
btn2  in  2  player 2 buttons
hit  in  1  one-cycle pulse: paddle hit
miss  in  1  one-cycle pulse: ball left field
miss_side  in  1  valid with miss; 0 = player 1 missed, 1 = player 2 missed
gra_still  out  1  1 = freeze ball/paddles
game_state  out  2  00 NEW, 01 PLAY, 10 NEWBALL, 11 OVER
balls_left  out  BALL_W  remaining serves
score1  out  SCORE_W  player 1 score
score2  out  SCORE_W  player 2 score
rally  out  RALLY_W  hits since last miss
winner  out  2  00 none, 01 p1, 10 p2, 11 draw

Behaviour:
- One clock, synchronous active-high reset; all outputs registered.
- Reset values: game_state=NEW, gra_still=1, balls_left=NUM_BALLS, score1=score2=0, rally=0, winner=00, timer=0.
- any_btn = (btn1|btn2) != 0. Level-sensitive; no debouncing here.
- NEW: gra_still=1. When any_btn: next state PLAY; balls_left <= NUM_BALLS-1; score1, score2, rally and winner cleared.
- PLAY: gra_still=0.
  - hit without miss: rally+1, saturating at all-ones.
  - miss: award a point to the opponent of miss_side (saturating at all-ones) and clear rally.
  - End condition: balls_left==0, or WIN_SCORE!=0 and the opponent's new score >= WIN_SCORE. On end: go to OVER, set winner from the post-update scores (greater score wins; equal gives 11), load timer=TIMER_CYCLES-1.
  - Otherwise: go to NEWBALL, balls_left-1, load timer=TIMER_CYCLES-1.
- hit and miss in the same cycle: miss wins and hit is ignored.
- NEWBALL: gra_still=1; timer decrements to 0 and holds there. Buttons are ignored while timer!=0. When timer==0 and any_btn: go to PLAY.
- OVER: gra_still=1; timer decrements. When timer==0: go to NEW. Scores and winner are held through OVER and NEW until the next start.
- hit/miss outside PLAY are ignored.
- gra_still and game_state update in the same cycle as the state register, with no added latency.
- Reset mid-game or mid-countdown returns every register to its reset value on the next edge.
- TIMER_CYCLES=1 gives a zero-wait pause: the timer is already 0 on the cycle after entry.

Decomposition:
- Shared package pong_pkg: state encodings (ST_NEW, ST_PLAY, ST_NEWBALL, ST_OVER) and winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW), for reuse by top and the text overlay.
- One sub-module, pong_timer: loadable down-counter with parameter TIMER_CYCLES, inputs load and clk/reset, output done (count==0). Width is $clog2(TIMER_CYCLES) with a minimum of 1.

Test Plan (bench parameters TIMER_CYCLES=4, NUM_BALLS=3, WIN_SCORE=7 unless stated):
- Reset, then btn1=01 for one cycle -> game_state=01, gra_still=0, balls_left=2, scores 0.
- In PLAY: 3 hit pulses, then miss with miss_side=0 -> rally 3 then 0, score2=1, game_state=10, balls_left=1. btn2 pressed during the 4-cycle countdown is ignored; the same press after the countdown -> PLAY.
- Exhaust the balls: misses with sides 0,1,0 -> final score2=2, score1=1, game_state=11, winner=10. After 4 cycles -> NEW with scores held; next button press clears them.
- WIN_SCORE=2, NUM_BALLS=3: two misses by player 2 -> score1=2, immediate OVER with balls_left=1, winner=01.
- hit and miss asserted in the same cycle -> rally cleared (not incremented), point awarded. Separately, hit/miss pulses in NEW or OVER -> no change to any output.
- Assert reset during the NEWBALL countdown -> next cycle all outputs equal their reset values.
